// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the CPU memory-bus responders: decoder slot base
// addresses, timer register offsets, the responder handshake state encoding
// and a byte-strobe merge helper.
// -----------------------------------------------------------------------------
package bus_pkg;

    // Decoder slot of the machine timer.
    localparam logic [31:0] TIMER_BASE = 32'hffff_0030;
    localparam int unsigned TIMER_SLOT = 3;

    // Timer register offsets, decoded from mem_addr[3:2].
    localparam logic [1:0] REG_MTIME_LO    = 2'd0;
    localparam logic [1:0] REG_MTIME_HI    = 2'd1;
    localparam logic [1:0] REG_MTIMECMP_LO = 2'd2;
    localparam logic [1:0] REG_MTIMECMP_HI = 2'd3;

    // Responder handshake: IDLE -> RESP -> HOLD -> IDLE.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StResp = 2'd1,
        StHold = 2'd2
    } resp_state_e;

    // Replace the bytes of old_val selected by strb with the matching bytes of new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_responder_fsm.sv
// -----------------------------------------------------------------------------
// bus_responder_fsm
// Handshake sequencer shared by all memory-bus responders. Accepts one
// transaction, answers with a single-cycle ready pulse, then waits for the
// request (or the select) to drop so that the decoder's registered ready path
// can never cause the same transaction to be accepted twice.
//
// Ports:
//   clk_i        system clock
//   resetn_i     synchronous reset, active low
//   enable_i     select strobe from the address decoder
//   mem_valid_i  CPU transaction request
//   accept_o     combinational; high on the cycle the transaction is taken
//   mem_ready_o  one-cycle response pulse, decoded from the state register
// -----------------------------------------------------------------------------
module bus_responder_fsm
    import bus_pkg::*;
(
    input  logic clk_i,
    input  logic resetn_i,
    input  logic enable_i,
    input  logic mem_valid_i,
    output logic accept_o,
    output logic mem_ready_o
);

    resp_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept_o    = 1'b0;
        mem_ready_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_valid_i && enable_i) begin
                    accept_o = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                mem_ready_o = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                // The CPU still sees the request as open until it samples ready.
                if (!mem_valid_i || !enable_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: rtl/timer_responder.sv
// -----------------------------------------------------------------------------
// timer_responder
// Memory-mapped 64-bit machine timer (mtime / mtimecmp) with a coherent
// LO-then-HI read scheme and a registered level interrupt.
//
// Register map (mem_addr[3:2]):
//   0 MTIME_LO     read returns mtime[31:0] and snapshots mtime[63:32]
//   1 MTIME_HI     read returns the snapshot taken by the last MTIME_LO read
//   2 MTIMECMP_LO
//   3 MTIMECMP_HI
//
// Ports:
//   clk        system clock
//   resetn     synchronous reset, active low
//   enable     select strobe from the address decoder
//   mem_valid  CPU transaction request
//   mem_addr   byte address, only [3:2] decoded
//   mem_wdata  write data
//   mem_wstrb  byte write strobes, 0 = read
//   mem_ready  one-cycle response pulse
//   mem_rdata  read data, held until the next response
//   irq        timer interrupt, (mtime >= mtimecmp) registered
// -----------------------------------------------------------------------------
module timer_responder
    import bus_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    localparam logic [15:0] PrescaleMax = 16'(PRESCALE - 1);

    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  reg_sel;
    logic        tick;
    logic [63:0] mtime_base;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_hi_q, shadow_hi_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:4], mem_addr[1:0]};

    bus_responder_fsm u_fsm (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .enable_i    (enable),
        .mem_valid_i (mem_valid),
        .accept_o    (accept),
        .mem_ready_o (mem_ready)
    );

    always_comb begin
        reg_sel = mem_addr[3:2];
        wr_en   = accept && (mem_wstrb != 4'b0000);
        rd_en   = accept && (mem_wstrb == 4'b0000);
        tick    = (pcnt_q == PrescaleMax);

        // Writes merge into the post-tick value so an increment is never lost.
        mtime_base  = tick ? (mtime_q + 64'd1) : mtime_q;
        mtime_d     = mtime_base;
        mtimecmp_d  = mtimecmp_q;
        shadow_hi_d = shadow_hi_q;
        rdata_d     = rdata_q;
        pcnt_d      = tick ? 16'd0 : (pcnt_q + 16'd1);
        irq_d       = (mtime_q >= mtimecmp_q);

        if (wr_en) begin
            unique case (reg_sel)
                REG_MTIME_LO: begin
                    mtime_d[31:0] = merge_bytes(mtime_base[31:0], mem_wdata, mem_wstrb);
                    pcnt_d        = 16'd0;
                end
                REG_MTIME_HI: begin
                    mtime_d[63:32] = merge_bytes(mtime_base[63:32], mem_wdata, mem_wstrb);
                    pcnt_d         = 16'd0;
                end
                REG_MTIMECMP_LO: begin
                    mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
                end
                REG_MTIMECMP_HI: begin
                    mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
                end
                default: ;
            endcase
            rdata_d = 32'h0;
        end

        if (rd_en) begin
            unique case (reg_sel)
                REG_MTIME_LO: begin
                    rdata_d     = mtime_q[31:0];
                    shadow_hi_d = mtime_q[63:32];
                end
                REG_MTIME_HI:    rdata_d = shadow_hi_q;
                REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mtime_q     <= 64'h0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_hi_q <= 32'h0;
            pcnt_q      <= 16'h0;
            rdata_q     <= 32'h0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            shadow_hi_q <= shadow_hi_d;
            pcnt_q      <= pcnt_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign irq       = irq_q;

endmodule
